// File: rtl/ram_dp_scrub_if.sv
// Bus bundle for ram_dp_scrub: one write port, one registered read port,
// the zeroize request, and the status outputs.
interface ram_dp_scrub_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic [DATA_W-1:0] data;
   logic [ADDR_W-1:0] addr;
   logic              we;
   logic [ADDR_W-1:0] raddr;
   logic              re;
   logic              zeroize;
   logic [DATA_W-1:0] Qout;
   logic              q_valid;
   logic              busy;

   modport master (
      output data, addr, we, raddr, re, zeroize,
      input  Qout, q_valid, busy
   );

   modport slave (
      input  data, addr, we, raddr, re, zeroize,
      output Qout, q_valid, busy
   );
endinterface

// File: rtl/ram_dp_scrub.sv
// Simple-dual-port RAM with a registered, write-first read port and a
// zeroize engine that clears every word after reset and on request.
// While the engine runs, user accesses are ignored.
module ram_dp_scrub #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 2**ADDR_W
) (
   input logic           clk,
   input logic           rst_n,
   ram_dp_scrub_if.slave bus
);
   typedef enum logic {SCRUB, IDLE} state_t;

   // DEPTH as an (ADDR_W+1)-bit value so DEPTH == 2**ADDR_W still compares correctly
   localparam logic [ADDR_W:0]   DEPTH_V = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] q_q;
   logic              vld_q;

   logic              wr_in, rd_in, fwd, user_ok;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_wa;
   logic [DATA_W-1:0] mem_wd, rd_data;

   assign wr_in = ({1'b0, bus.addr}  < DEPTH_V);
   assign rd_in = ({1'b0, bus.raddr} < DEPTH_V);
   assign fwd   = bus.we && wr_in && (bus.addr == bus.raddr);

   // Scrub engine next state and the single write-port mux (scrub wins over user)
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      mem_we  = 1'b0;
      mem_wa  = ptr_q;
      mem_wd  = '0;
      user_ok = 1'b0;
      case (state_q)
         SCRUB: begin
            mem_we = 1'b1;
            if (bus.zeroize) begin
               // restart: this edge clears word 0, the full pass follows
               mem_wa = '0;
               ptr_d  = '0;
            end else if (ptr_q == LAST) begin
               state_d = IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         default: begin
            if (bus.zeroize) begin
               state_d = SCRUB;
               ptr_d   = '0;
            end else begin
               user_ok = 1'b1;
               if (bus.we && wr_in) begin
                  mem_we = 1'b1;
                  mem_wa = bus.addr;
                  mem_wd = bus.data;
               end
            end
         end
      endcase
   end

   // Read data source: forwarded write data, stored word, or 0 beyond DEPTH
   always_comb begin
      rd_data = '0;
      if (fwd)        rd_data = bus.data;
      else if (rd_in) rd_data = mem[bus.raddr];
   end

   // Scrub engine state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SCRUB;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Storage array; deliberately unreset, the scrub pass clears it
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
   end

   // Registered read port; Qout holds whenever no read is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q   <= '0;
         vld_q <= 1'b0;
      end else if (user_ok && bus.re) begin
         q_q   <= rd_data;
         vld_q <= 1'b1;
      end else begin
         vld_q <= 1'b0;
      end
   end

   assign bus.Qout    = q_q;
   assign bus.q_valid = vld_q;
   assign bus.busy    = (state_q == SCRUB);
endmodule

// File: tb/tb_ram_dp_scrub.sv
// Bench for ram_dp_scrub: a default 8x256 instance checked every cycle
// against an array-based reference model, plus a 16-bit, 10-word instance
// exercised with directed sequences.
module tb_ram_dp_scrub;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ram_dp_scrub_if #(.DATA_W(8),  .ADDR_W(8)) ia ();
   ram_dp_scrub_if #(.DATA_W(16), .ADDR_W(4)) ib ();

   ram_dp_scrub #(.DATA_W(8), .ADDR_W(8)) ua (
      .clk(clk), .rst_n(rst_n), .bus(ia)
   );
   ram_dp_scrub #(.DATA_W(16), .ADDR_W(4), .DEPTH(10)) ub (
      .clk(clk), .rst_n(rst_n), .bus(ib)
   );

   int errors = 0;
   int checks = 0;

   // Reference model for ua: a zeroize clears the whole array at once and
   // leaves a count of busy cycles; idle edges write first, then read.
   logic [7:0] m_mem [256];
   int         m_left;
   logic [7:0] m_q;
   logic       m_v;

   typedef struct {
      logic       we;
      logic [7:0] addr;
      logic [7:0] data;
      logic       re;
      logic [7:0] raddr;
      logic       exp_v;
      logic [7:0] exp_q;
   } vec_t;

   function automatic void chk(string name, logic [15:0] act, logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endfunction

   function automatic void model_reset();
      foreach (m_mem[i]) m_mem[i] = 8'h00;
      m_left = 256;
      m_q    = 8'h00;
      m_v    = 1'b0;
   endfunction

   function automatic void model_edge();
      if (ia.zeroize) begin
         foreach (m_mem[i]) m_mem[i] = 8'h00;
         m_left = 256;
         m_v    = 1'b0;
      end else if (m_left > 0) begin
         m_left--;
         m_v = 1'b0;
      end else begin
         if (ia.we) m_mem[ia.addr] = ia.data;
         m_v = ia.re;
         if (ia.re) m_q = m_mem[ia.raddr];
      end
   endfunction

   // One clock edge; ua outputs are compared with the model 1 time unit later
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("a_busy",    16'(ia.busy),    16'(m_left != 0));
      chk("a_q_valid", 16'(ia.q_valid), 16'(m_v));
      chk("a_qout",    16'(ia.Qout),    16'(m_q));
   endtask

   task automatic idle_a();
      ia.we = 1'b0; ia.re = 1'b0; ia.zeroize = 1'b0;
      ia.addr = '0; ia.raddr = '0; ia.data = '0;
   endtask

   task automatic idle_b();
      ib.we = 1'b0; ib.re = 1'b0; ib.zeroize = 1'b0;
      ib.addr = '0; ib.raddr = '0; ib.data = '0;
   endtask

   task automatic wait_idle_a(output int n);
      n = 0;
      while (ia.busy && n < 1000) begin
         tick();
         n++;
      end
   endtask

   task automatic rd_a(input logic [7:0] ra, input logic [7:0] exp, input string name);
      ia.re = 1'b1; ia.raddr = ra;
      tick();
      ia.re = 1'b0;
      chk({name, "_v"}, 16'(ia.q_valid), 16'd1);
      chk(name, 16'(ia.Qout), 16'(exp));
   endtask

   task automatic rd_b(input logic [3:0] ra, input logic [15:0] exp, input string name);
      ib.re = 1'b1; ib.raddr = ra;
      tick();
      ib.re = 1'b0;
      chk({name, "_v"}, 16'(ib.q_valid), 16'd1);
      chk(name, ib.Qout, exp);
   endtask

   function automatic vec_t mk(logic we, logic [7:0] a, logic [7:0] d, logic re,
                               logic [7:0] ra, logic ev, logic [7:0] eq);
      vec_t v;
      v.we = we; v.addr = a; v.data = d; v.re = re; v.raddr = ra;
      v.exp_v = ev; v.exp_q = eq;
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t tbl[$];
      int   n, nb;

      for (int i = 0; i < 6; i++) tbl.push_back(mk(1, 8'(i), 8'(i + 1), 0, 0, 0, 8'h00));
      for (int i = 0; i < 6; i++) tbl.push_back(mk(0, 0, 0, 1, 8'(i), 1, 8'(i + 1)));
      tbl.push_back(mk(0, 0,     0,     0, 0,     0, 8'h06)); // re=0: Qout holds
      tbl.push_back(mk(1, 8'd10, 8'h3C, 0, 0,     0, 8'h06));
      tbl.push_back(mk(1, 8'd10, 8'hA5, 1, 8'd10, 1, 8'hA5)); // write-first
      tbl.push_back(mk(0, 0,     0,     1, 8'd10, 1, 8'hA5));
      tbl.push_back(mk(1, 8'd11, 8'h77, 1, 8'd10, 1, 8'hA5)); // different address
      tbl.push_back(mk(0, 0,     0,     1, 8'd11, 1, 8'h77));

      idle_a();
      idle_b();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_a_busy", 16'(ia.busy),    16'd1);
      chk("rst_a_v",    16'(ia.q_valid), 16'd0);
      chk("rst_a_q",    16'(ia.Qout),    16'd0);
      chk("rst_b_busy", 16'(ib.busy),    16'd1);
      chk("rst_b_q",    ib.Qout,         16'd0);
      rst_n = 1'b1;

      // power-up scrub length for both instances
      n  = 0;
      nb = -1;
      while (ia.busy && n < 1000) begin
         tick();
         n++;
         if (nb < 0 && !ib.busy) nb = n;
      end
      chk("a_reset_scrub_len", 16'(n),  16'd256);
      chk("b_reset_scrub_len", 16'(nb), 16'd10);

      // every word reads back as zero after the scrub
      for (int i = 0; i < 256; i++) rd_a(8'(i), 8'h00, "sweep_zero");

      foreach (tbl[i]) begin
         ia.we = tbl[i].we; ia.addr = tbl[i].addr; ia.data = tbl[i].data;
         ia.re = tbl[i].re; ia.raddr = tbl[i].raddr;
         tick();
         chk($sformatf("vec%0d_v", i), 16'(ia.q_valid), 16'(tbl[i].exp_v));
         chk($sformatf("vec%0d_q", i), 16'(ia.Qout),    16'(tbl[i].exp_q));
      end
      idle_a();

      // zeroize: stored FF disappears, writes during busy are dropped
      ia.we = 1'b1; ia.addr = 8'h80; ia.data = 8'hFF;
      tick();
      idle_a();
      rd_a(8'h80, 8'hFF, "pre_zeroize");
      ia.zeroize = 1'b1;
      tick();
      ia.zeroize = 1'b0;
      chk("zeroize_busy", 16'(ia.busy), 16'd1);
      ia.we = 1'b1; ia.addr = 8'h81; ia.data = 8'h11;
      ia.re = 1'b1; ia.raddr = 8'h80;
      wait_idle_a(n);
      idle_a();
      chk("zeroize_len", 16'(n), 16'd256);
      rd_a(8'h80, 8'h00, "post_zeroize_80");
      rd_a(8'h81, 8'h00, "dropped_write_81");

      // second request 100 cycles into a scrub: 256 more busy cycles (356 total)
      ia.zeroize = 1'b1;
      tick();
      ia.zeroize = 1'b0;
      repeat (99) tick();
      ia.zeroize = 1'b1;
      tick();
      ia.zeroize = 1'b0;
      wait_idle_a(n);
      chk("restart_len", 16'(n), 16'd256);
      chk("restart_total", 16'(100 + n), 16'd356);

      // zeroize held high keeps the engine busy
      ia.zeroize = 1'b1;
      repeat (20) tick();
      chk("held_busy", 16'(ia.busy), 16'd1);
      ia.zeroize = 1'b0;
      wait_idle_a(n);
      chk("held_len", 16'(n), 16'd256);

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         ia.we      = 1'($urandom_range(1));
         ia.re      = 1'($urandom_range(1));
         ia.data    = 8'($urandom);
         ia.addr    = ($urandom_range(3) == 0) ? 8'($urandom) : 8'($urandom_range(15));
         ia.raddr   = ($urandom_range(3) == 0) ? 8'($urandom) : 8'($urandom_range(15));
         ia.zeroize = ($urandom_range(399) == 0);
         tick();
      end
      idle_a();
      wait_idle_a(n);

      // asynchronous reset in the middle of a read
      ia.we = 1'b1; ia.addr = 8'd3; ia.data = 8'h5A;
      tick();
      idle_a();
      rd_a(8'd3, 8'h5A, "pre_reset_rd");
      rst_n = 1'b0;
      #1;
      chk("async_rst_a_q",    16'(ia.Qout),    16'd0);
      chk("async_rst_a_v",    16'(ia.q_valid), 16'd0);
      chk("async_rst_a_busy", 16'(ia.busy),    16'd1);
      chk("async_rst_b_busy", 16'(ib.busy),    16'd1);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_idle_a(n);
      chk("rst_rescrub_len", 16'(n), 16'd256);
      rd_a(8'd3, 8'h00, "post_reset_rd");

      // 16x10 instance: scrub length, out-of-range drop, in-range access
      ib.zeroize = 1'b1;
      tick();
      ib.zeroize = 1'b0;
      nb = 0;
      while (ib.busy && nb < 100) begin
         tick();
         nb++;
      end
      chk("b_zeroize_len", 16'(nb), 16'd10);
      ib.we = 1'b1; ib.addr = 4'd12; ib.data = 16'hBEEF;
      tick();
      idle_b();
      rd_b(4'd12, 16'h0000, "b_rd_12");
      ib.we = 1'b1; ib.addr = 4'd9; ib.data = 16'h1234;
      tick();
      idle_b();
      rd_b(4'd9, 16'h1234, "b_rd_9");
      ib.we = 1'b1; ib.addr = 4'd15; ib.data = 16'h5678;
      rd_b(4'd15, 16'h0000, "b_fwd_out_of_range");
      ib.we = 1'b1; ib.addr = 4'd9; ib.data = 16'h5678;
      rd_b(4'd9, 16'h5678, "b_fwd_9");
      idle_b();
      tick();
      chk("b_idle_v", 16'(ib.q_valid), 16'd0);
      chk("b_idle_q", ib.Qout, 16'h5678);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ram_dp_scrub.md
# ram_dp_scrub

Parametrised simple-dual-port synchronous RAM for the 8-bit crypto processor. It succeeds the original single-port 8×256 RAM with separate write and read ports, a registered read with a valid flag, and write-first forwarding. A built-in zeroize engine clears every word after reset and on request, so key material never survives a reset or a context switch. It sits between the processor datapath and the key/state storage region.

## Interface
- DATA_W, 8, word width in bits
- ADDR_W, 8, address width in bits
- DEPTH, 2**ADDR_W, number of implemented words (1..2**ADDR_W)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- data  input  DATA_W  write data
- addr  input  ADDR_W  write address
- we  input  1  write enable
- raddr  input  ADDR_W  read address
- re  input  1  read enable
- zeroize  input  1  request to clear all words, sampled on rising edge
- Qout  output  DATA_W  registered read data
- q_valid  output  1  Qout holds the result of a read issued on the previous edge
- busy  output  1  zeroize engine active; user writes and reads are ignored

## Operation
- FSM states: SCRUB and IDLE. Scrub pointer is ADDR_W bits wide.
- Reset (rst_n=0, asynchronous): state=SCRUB, ptr=0, busy=1, Qout=0, q_valid=0. The memory array itself is not reset; the scrub pass clears it.
- SCRUB: each edge writes 0 to mem[ptr] and increments ptr. On the edge that writes ptr=DEPTH-1: state→IDLE, busy→0, ptr→0.
- IDLE + zeroize=1 on an edge: state→SCRUB, ptr=0, busy=1. That edge performs no user write or read.
- SCRUB + zeroize=1: the scrub restarts at ptr=0. The zeroize edge itself writes mem[0].
- While busy=1: we and re are ignored, q_valid=0, and Qout holds its last value.
- IDLE write: we=1 and addr<DEPTH writes mem[addr]=data. If addr≥DEPTH, the write is dropped silently.
- IDLE read: re=1 loads Qout on the same edge with mem[raddr], or with 0 if raddr≥DEPTH. q_valid=1 for the following cycle. If re=0, q_valid=0 and Qout holds.
- Read-during-write to the same address (we=re=1, addr==raddr<DEPTH): write-first, so Qout gets the new data.
- Widths: all address compares are ADDR_W-bit unsigned. No arithmetic on data.

## Timing
- Read latency: 1 cycle. raddr/re sampled at edge N gives Qout/q_valid valid after edge N until edge N+1.
- Write latency: 1 cycle. The data is readable by a read issued on the next edge, or on the same edge through forwarding.
- Scrub duration: exactly DEPTH edges after rst_n release (or after the zeroize edge). busy is 1 for those DEPTH cycles, then falls with state→IDLE.
- The first user access is accepted on the edge after busy is sampled 0.
- Reset asserted mid-scrub or mid-access: outputs go to reset values immediately, and a full scrub restarts when rst_n rises.
- zeroize is level-sampled. If it is held high, SCRUB restarts every cycle and busy stays 1.

## Test plan
- Reset release, DEPTH=256: busy=1 for 256 cycles then 0. Read addresses 0..255 → every Qout=00 with q_valid=1.
- Write 01..06 to addresses 0..5, then read 0..5 with re=1 → Qout=01..06, each one cycle after its raddr, q_valid=1. With re=0, q_valid=0 and Qout holds 06.
- Write-first: we=re=1, addr=raddr=10, data=A5 over old 3C → Qout=A5 on the next cycle.
- Zeroize: write FF at 0x80, pulse zeroize → busy=1 for 256 cycles. A write of 11 during busy is dropped. Read 0x80 afterwards → 00.
- Zeroize restart: assert zeroize again 100 cycles into a scrub → busy stays high for 256 cycles from the second request (356 total).
- Parametrised instance DATA_W=16, ADDR_W=4, DEPTH=10: scrub lasts 10 cycles. Write BEEF at address 12 is dropped, and a read of 12 → 0000. A write/read at address 9 returns 1234.
